// File: rtl/stall_ctrl_pkg.sv
// Shared types and constants for the ID-stage stall controller.
package stall_ctrl_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Total stall cycles each hazard class requires
  localparam logic [3:0] STALL_NONE     = 4'd0;
  localparam logic [3:0] STALL_LOAD_USE = 4'd1;
  localparam logic [3:0] STALL_BR_ALU   = 4'd1;
  localparam logic [3:0] STALL_BR_LOAD  = 4'd2;

  function automatic logic [3:0] max_len(input logic [3:0] a, input logic [3:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/stall_ctrl_hazard_detect.sv
// Combinational hazard matching; returns the longest stall length required.
// Mul/div stalls exist only when STALL_CTRL_MULDIV_EN is defined.
module hazard_detect
  import stall_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 8
) (
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       ex_mem_read,
  input  logic       ex_reg_write,
  input  logic [4:0] ex_write_reg,
  input  logic       branch,
  input  logic       mul_div,
  output logic [3:0] stall_len
);

  logic src_match;
  logic load_use;
  logic br_alu;
  logic br_load;
  logic [3:0] md_len;

  // Register 0 never matches: a zero destination cannot create a hazard
  assign src_match = (ex_write_reg != REG_ZERO) &&
                     ((ex_write_reg == rs) || (ex_write_reg == rt));
  assign load_use  = ex_mem_read && src_match;
  assign br_alu    = branch && ex_reg_write && !ex_mem_read && src_match;
  assign br_load   = branch && load_use;

`ifdef STALL_CTRL_MULDIV_EN
  assign md_len = mul_div ? 4'(DIV_CYCLES - 1) : STALL_NONE;
`else
  logic unused_muldiv;
  assign unused_muldiv = mul_div ^ DIV_CYCLES[0];
  assign md_len        = STALL_NONE;
`endif

  always_comb begin
    stall_len = STALL_NONE;
    if (load_use) stall_len = max_len(stall_len, STALL_LOAD_USE);
    if (br_alu)   stall_len = max_len(stall_len, STALL_BR_ALU);
    if (br_load)  stall_len = max_len(stall_len, STALL_BR_LOAD);
    stall_len = max_len(stall_len, md_len);
  end

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall controller: RUN/HOLD FSM, hold counter and stall statistics.
// Optional feature macro: STALL_CTRL_MULDIV_EN (multi-cycle mul/div stalls).
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  IFID_Rs,
  input  logic [4:0]  IFID_Rt,
  input  logic        IDEX_MemRead,
  input  logic        IDEX_RegWrite,
  input  logic [4:0]  IDEX_WriteReg,
  input  logic        ID_Branch,
  input  logic        ID_MulDiv,
  input  logic        BranchTaken,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IFIDFlush,
  output logic        IDEXBubble,
  output logic [31:0] StallCount
);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] count_reg;
  logic [3:0]  stall_len;
  logic        stall;
  logic        mul_div;

`ifdef STALL_CTRL_MULDIV_EN
  // The mul/div stays in ID for its release cycle; mask it so it does not re-arm
  logic release_reg;
  assign mul_div = ID_MulDiv & ~release_reg;
`else
  assign mul_div = ID_MulDiv;
`endif

  hazard_detect #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_hazard_detect (
    .rs          (IFID_Rs),
    .rt          (IFID_Rt),
    .ex_mem_read (IDEX_MemRead),
    .ex_reg_write(IDEX_RegWrite),
    .ex_write_reg(IDEX_WriteReg),
    .branch      (ID_Branch),
    .mul_div     (mul_div),
    .stall_len   (stall_len)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stall      = 1'b0;
    case (state_reg)
      RUN: begin
        if (stall_len != STALL_NONE) begin
          stall = 1'b1;
          if (stall_len > 4'd1) begin
            cnt_next   = stall_len - 4'd2;
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        stall = 1'b1;
        if (cnt_reg == 4'd0) state_next = RUN;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      default: state_next = RUN;
    endcase
    if (Reset) stall = 1'b0;
  end

  assign PCWrite    = ~stall;
  assign IFIDWrite  = ~stall;
  assign IDEXBubble = stall;
  assign IFIDFlush  = ~stall & ~Reset & BranchTaken;
  assign StallCount = count_reg;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= RUN;
      cnt_reg   <= 4'd0;
      count_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (stall && (count_reg != 32'hFFFF_FFFF)) count_reg <= count_reg + 32'd1;
    end
  end

`ifdef STALL_CTRL_MULDIV_EN
  always_ff @(posedge Clk) begin
    if (Reset) release_reg <= 1'b0;
    else       release_reg <= stall && (state_next == RUN);
  end
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed self-checking bench for stall_ctrl; honours STALL_CTRL_MULDIV_EN.
module tb_stall_ctrl;

  localparam int DIV_CYCLES = 8;
`ifdef STALL_CTRL_MULDIV_EN
  localparam int MD_STALLS = DIV_CYCLES - 1;
`else
  localparam int MD_STALLS = 0;
`endif

  // Output vector order: {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush}
  localparam logic [3:0] O_RUN   = 4'b1100;
  localparam logic [3:0] O_FLUSH = 4'b1101;
  localparam logic [3:0] O_STALL = 4'b0010;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [4:0]  IFID_Rs = '0, IFID_Rt = '0, IDEX_WriteReg = '0;
  logic        IDEX_MemRead = 1'b0, IDEX_RegWrite = 1'b0;
  logic        ID_Branch = 1'b0, ID_MulDiv = 1'b0, BranchTaken = 1'b0;
  logic        PCWrite, IFIDWrite, IFIDFlush, IDEXBubble;
  logic [31:0] StallCount;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  stall_ctrl #(.DIV_CYCLES(DIV_CYCLES)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .IFID_Rs      (IFID_Rs),
    .IFID_Rt      (IFID_Rt),
    .IDEX_MemRead (IDEX_MemRead),
    .IDEX_RegWrite(IDEX_RegWrite),
    .IDEX_WriteReg(IDEX_WriteReg),
    .ID_Branch    (ID_Branch),
    .ID_MulDiv    (ID_MulDiv),
    .BranchTaken  (BranchTaken),
    .PCWrite      (PCWrite),
    .IFIDWrite    (IFIDWrite),
    .IFIDFlush    (IFIDFlush),
    .IDEXBubble   (IDEXBubble),
    .StallCount   (StallCount)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  // Apply one cycle of inputs just after the edge; leave time to settle mid-cycle
  task automatic drive(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                       input logic mr, input logic rw, input logic [4:0] wr,
                       input logic br, input logic md, input logic bt);
    @(posedge Clk);
    #1;
    Reset = rst; IFID_Rs = rs; IFID_Rt = rt; IDEX_MemRead = mr; IDEX_RegWrite = rw;
    IDEX_WriteReg = wr; ID_Branch = br; ID_MulDiv = md; BranchTaken = bt;
    #4;
  endtask

  task automatic check_out(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, PCWrite, IFIDWrite, IDEXBubble, IFIDFlush}, {28'd0, exp});
  endtask

  initial begin
    // Reset overrides a live load-use hazard
    drive(1, 5'd9, 5'd0, 1, 1, 5'd9, 0, 0, 1);
    check_out("rst_out", O_RUN);
    drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    check_out("idle", O_RUN);
    check("rst_cnt", StallCount, 32'd0);

    // Load to $zero, ID reads $zero
    drive(0, 5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0);
    check_out("zero_reg", O_RUN);
    drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    check("zero_cnt", StallCount, 32'd0);

    // Load-use on Rs then on Rt
    drive(0, 5'd9, 5'd0, 1, 1, 5'd9, 0, 0, 0);
    check_out("lu_rs", O_STALL);
    drive(0, 5'd9, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    check_out("lu_rs_rel", O_RUN);
    exp_cnt = 1;
    check("lu_rs_cnt", StallCount, exp_cnt);
    drive(0, 5'd0, 5'd10, 1, 1, 5'd10, 0, 0, 0);
    check_out("lu_rt", O_STALL);
    drive(0, 5'd0, 5'd10, 0, 0, 5'd0, 0, 0, 0);
    check_out("lu_rt_rel", O_RUN);
    exp_cnt = 2;
    check("lu_rt_cnt", StallCount, exp_cnt);

    // Branch on ALU result; BranchTaken ignored while stalled
    drive(0, 5'd8, 5'd0, 0, 1, 5'd8, 1, 0, 1);
    check_out("bralu_stall", O_STALL);
    drive(0, 5'd8, 5'd0, 0, 0, 5'd0, 1, 0, 1);
    check_out("bralu_flush", O_FLUSH);
    exp_cnt = 3;
    check("bralu_cnt", StallCount, exp_cnt);

    // Branch on load: two stalls, flush only in the third cycle
    drive(0, 5'd9, 5'd0, 1, 1, 5'd9, 1, 0, 1);
    check_out("brld_s1", O_STALL);
    drive(0, 5'd9, 5'd0, 0, 0, 5'd0, 1, 0, 1);
    check_out("brld_s2", O_STALL);
    drive(0, 5'd9, 5'd0, 0, 0, 5'd0, 1, 0, 1);
    check_out("brld_flush", O_FLUSH);
    drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    check_out("brld_after", O_RUN);
    exp_cnt = 5;
    check("brld_cnt", StallCount, exp_cnt);

    // No hazard: ALU writer without branch, branch with non-matching sources
    drive(0, 5'd8, 5'd0, 0, 1, 5'd8, 0, 0, 0);
    check_out("alu_nobr", O_RUN);
    drive(0, 5'd3, 5'd4, 1, 1, 5'd5, 1, 0, 0);
    check_out("br_nomatch", O_RUN);

    // Mul/div: held in ID for the whole stall and its release cycle
    for (int i = 0; i < MD_STALLS; i++) begin
      drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0);
      check_out($sformatf("md_stall%0d", i), O_STALL);
    end
    drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0);
    check_out("md_release", O_RUN);
    drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    check_out("md_after", O_RUN);
    exp_cnt = 5 + MD_STALLS;
    check("md_cnt", StallCount, exp_cnt);

    // Reset in the middle of a HOLD sequence
`ifdef STALL_CTRL_MULDIV_EN
    drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0);
    check_out("hold_s1", O_STALL);
    drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0);
    check_out("hold_s2", O_STALL);
    drive(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0);
    check_out("hold_rst", O_RUN);
`else
    drive(0, 5'd9, 5'd0, 1, 1, 5'd9, 1, 0, 0);
    check_out("hold_s1", O_STALL);
    drive(1, 5'd9, 5'd0, 0, 0, 5'd0, 1, 0, 0);
    check_out("hold_rst", O_RUN);
`endif
    drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    check_out("post_rst_run", O_RUN);
    check("post_rst_cnt", StallCount, 32'd0);

    // Normal detection resumes after reset
    drive(0, 5'd7, 5'd0, 1, 1, 5'd7, 0, 0, 0);
    check_out("post_lu", O_STALL);
    drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    check_out("post_lu_rel", O_RUN);
    check("post_lu_cnt", StallCount, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
